// File: rtl/audio_frame_mux.sv
// Multi-channel audio frame FIFO with an Avalon-MM read mux; read data is registered (1-cycle latency).
// No backpressure on sample_strobe: a frame arriving while full is dropped and flagged in overflow.
module audio_frame_mux #(
   parameter int NUM_CH   = 2,
   parameter int SAMPLE_W = 24,
   parameter int DEPTH    = 16,
   parameter int JUSTIFY  = 0,
   parameter int ADDR_W   = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_strobe,
   input  logic [NUM_CH*SAMPLE_W-1:0]   sound_in,
   input  logic [ADDR_W-1:0]            address,
   input  logic                         read,
   output logic [31:0]                  readdata,
   output logic                         readdatavalid,
   output logic [NUM_CH-1:0]            ch_read,
   output logic                         sample_ready,
   output logic                         overflow
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W   = PTR_W + 1;
   localparam int FRAME_W = NUM_CH * SAMPLE_W;

   localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_CH);
   localparam logic [ADDR_W-1:0] LAST_CH   = ADDR_W'(NUM_CH - 1);
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

   logic [FRAME_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    level;
   logic [LVL_W-1:0]    level_nxt;
   logic                underflow;

   logic                fifo_empty;
   logic                fifo_full;
   logic                ch_rd;
   logic                stat_rd;
   logic                pop;
   logic                push;
   logic                drop;
   logic                under_set;

   logic [FRAME_W-1:0]  head;
   logic [SAMPLE_W-1:0] head_sample;
   logic [31:0]         sample_ext;
   logic [31:0]         chan_word;
   logic [31:0]         status_word;
   logic [31:0]         rdata_nxt;

   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == FULL_LVL);
   assign ch_rd      = read && (address < STAT_ADDR);
   assign stat_rd    = read && (address == STAT_ADDR);
   assign under_set  = ch_rd && fifo_empty;

   // Reading the last channel retires the head frame, which also frees a slot
   // for a frame arriving in the same cycle.
   assign pop        = read && (address == LAST_CH) && !fifo_empty;
   assign push       = sample_strobe && (!fifo_full || pop);
   assign drop       = sample_strobe && fifo_full && !pop;
   assign level_nxt  = level + LVL_W'(push) - LVL_W'(pop);

   assign head       = mem[rd_ptr];

   always_comb begin
      ch_read     = '0;
      head_sample = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (address == ADDR_W'(k)) begin
            ch_read[k]  = read;
            head_sample = head[k*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   always_comb begin
      sample_ext = 32'(head_sample);
      if (JUSTIFY != 0) begin
         chan_word = 32'($signed(head_sample));
      end else begin
         chan_word = sample_ext << (32 - SAMPLE_W);
      end
   end

   assign status_word = {14'd0, underflow, overflow, 16'(level)};

   always_comb begin
      rdata_nxt = '0;
      if (ch_rd) begin
         rdata_nxt = fifo_empty ? 32'd0 : chan_word;
      end else if (stat_rd) begin
         rdata_nxt = status_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         readdata      <= '0;
         readdatavalid <= 1'b0;
         sample_ready  <= 1'b0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level         <= level_nxt;
         sample_ready  <= (level_nxt != '0);
         readdatavalid <= read;
         if (read) begin
            readdata <= rdata_nxt;
         end
         // A status read clears the sticky flags unless a new event lands in the same cycle.
         overflow  <= drop | (overflow & ~stat_rd);
         underflow <= under_set | (underflow & ~stat_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr] <= sound_in;
      end
   end

endmodule

// File: tb/tb_audio_frame_mux.sv
// Bench for audio_frame_mux: directed vector table plus randomized traffic against a queue-based model.
module tb_audio_frame_mux;

   logic        clk;
   logic        reset;
   logic        sample_strobe;
   logic [47:0] sound_in;
   logic [3:0]  address;
   logic        read;

   logic [31:0] readdata0, readdata1;
   logic        readdatavalid0, readdatavalid1;
   logic [1:0]  ch_read0, ch_read1;
   logic        sample_ready0, sample_ready1;
   logic        overflow0, overflow1;

   int n_checks = 0;
   int n_errors = 0;

   logic [47:0] mq[$];
   logic        m_ovf = 1'b0;
   logic        m_und = 1'b0;

   audio_frame_mux #(.NUM_CH(2), .SAMPLE_W(24), .DEPTH(4), .JUSTIFY(0), .ADDR_W(4)) dut_left (
      .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .sound_in(sound_in),
      .address(address), .read(read), .readdata(readdata0), .readdatavalid(readdatavalid0),
      .ch_read(ch_read0), .sample_ready(sample_ready0), .overflow(overflow0)
   );

   audio_frame_mux #(.NUM_CH(2), .SAMPLE_W(24), .DEPTH(4), .JUSTIFY(1), .ADDR_W(4)) dut_right (
      .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .sound_in(sound_in),
      .address(address), .read(read), .readdata(readdata1), .readdatavalid(readdatavalid1),
      .ch_read(ch_read1), .sample_ready(sample_ready1), .overflow(overflow1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        st;
      logic [47:0] fr;
      logic        rd;
      logic [3:0]  ad;
      logic        rs;
      logic        ev;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        rdy;
      logic        ovf;
   } vec_t;

   function automatic vec_t mk(logic st, logic [47:0] fr, logic rd, logic [3:0] ad, logic rs,
                               logic ev, logic [31:0] d0, logic [31:0] d1, logic rdy, logic ovf);
      vec_t v;
      v.st = st; v.fr = fr; v.rd = rd; v.ad = ad; v.rs = rs;
      v.ev = ev; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.ovf = ovf;
      return v;
   endfunction

   function automatic logic [31:0] lj(logic [23:0] s);
      return {s, 8'h00};
   endfunction

   function automatic logic [31:0] rj(logic [23:0] s);
      return {{8{s[23]}}, s};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // Drives one cycle, advances the reference model, and compares all outputs.
   task automatic step(input logic st, input logic [47:0] fr, input logic rd,
                       input logic [3:0] ad, input logic rs);
      logic [31:0] e0, e1;
      logic [47:0] hf;
      logic [23:0] smp;
      logic        ev, pop, ov_set, un_set, stat;
      int          n, k;
      sample_strobe = st; sound_in = fr; read = rd; address = ad; reset = rs;
      #1;
      k = int'(ad);
      chk("ch_read_left",  32'(ch_read0), (rd && k < 2) ? (32'd1 << k) : 32'd0);
      chk("ch_read_right", 32'(ch_read1), (rd && k < 2) ? (32'd1 << k) : 32'd0);
      e0 = '0; e1 = '0; ev = 1'b0; pop = 1'b0; ov_set = 1'b0; un_set = 1'b0;
      n = mq.size();
      stat = rd && (k == 2);
      if (rs) begin
         mq.delete();
         m_ovf = 1'b0;
         m_und = 1'b0;
      end else begin
         ev = rd;
         if (rd && k < 2) begin
            if (n == 0) begin
               un_set = 1'b1;
            end else begin
               hf  = mq[0];
               smp = hf[k*24 +: 24];
               e0  = lj(smp);
               e1  = rj(smp);
               pop = (k == 1);
            end
         end else if (stat) begin
            e0 = {14'd0, m_und, m_ovf, 16'(n)};
            e1 = e0;
         end
         if (pop) void'(mq.pop_front());
         if (st) begin
            if (mq.size() < 4) mq.push_back(fr);
            else ov_set = 1'b1;
         end
         m_ovf = ov_set | (m_ovf & !stat);
         m_und = un_set | (m_und & !stat);
      end
      @(posedge clk);
      #1;
      chk("valid_left",  32'(readdatavalid0), 32'(ev));
      chk("valid_right", 32'(readdatavalid1), 32'(ev));
      if (ev || rs) begin
         chk("data_left",  readdata0, e0);
         chk("data_right", readdata1, e1);
      end
      chk("ready_left",  32'(sample_ready0), 32'(mq.size() != 0));
      chk("ready_right", 32'(sample_ready1), 32'(mq.size() != 0));
      chk("ovf_left",    32'(overflow0), 32'(m_ovf));
      chk("ovf_right",   32'(overflow1), 32'(m_ovf));
   endtask

   localparam logic [47:0] F1 = 48'hABCDEF_123456;
   localparam logic [47:0] F2 = 48'h7FFFFF_800001;
   localparam logic [47:0] FA = 48'h900001_100001;
   localparam logic [47:0] FB = 48'h900002_100002;
   localparam logic [47:0] FC = 48'h900003_100003;
   localparam logic [47:0] FD = 48'h900004_100004;
   localparam logic [47:0] FE = 48'h900005_100005;
   localparam logic [47:0] FF = 48'h900006_100006;
   localparam logic [47:0] FG = 48'h900007_100007;

   vec_t tbl[$];

   initial begin
      logic [63:0] r64;
      logic        st, rd, rs;
      logic [3:0]  ad;
      int          r;

      sample_strobe = 1'b0; sound_in = '0; read = 1'b0; address = '0; reset = 1'b1;

      //                st  frame rd ad rs  ev  data_left     data_right    rdy ovf
      tbl.push_back(mk(0, '0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(1, F1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, 32'h12345600, 32'h00123456, 1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, 32'h12345600, 32'h00123456, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'hABCDEF00, 32'hFFABCDEF, 0, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h00020000, 32'h00020000, 0, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(1, F2, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, 32'h80000100, 32'hFF800001, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h7FFFFF00, 32'h007FFFFF, 0, 0));
      tbl.push_back(mk(0, '0, 1, 3, 0, 1, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(1, FA, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FB, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FC, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FD, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FE, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h00010004, 32'h00010004, 1, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h00000004, 32'h00000004, 1, 0));
      tbl.push_back(mk(1, FF, 1, 1, 0, 1, 32'h90000100, 32'hFF900001, 1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 1, 32'h10000200, 32'h00100002, 1, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h00000004, 32'h00000004, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h90000200, 32'hFF900002, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h90000300, 32'hFF900003, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h90000400, 32'hFF900004, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h90000600, 32'hFF900006, 0, 0));
      tbl.push_back(mk(1, FA, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FB, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(1, FC, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(0, '0, 1, 0, 1, 0, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h0,        32'h0,        0, 0));
      tbl.push_back(mk(1, FG, 1, 0, 0, 1, 32'h0,        32'h0,        1, 0));
      tbl.push_back(mk(0, '0, 1, 2, 0, 1, 32'h00020001, 32'h00020001, 1, 0));
      tbl.push_back(mk(0, '0, 1, 1, 0, 1, 32'h90000700, 32'hFF900007, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].fr, tbl[i].rd, tbl[i].ad, tbl[i].rs);
         chk($sformatf("vec%0d_valid_left", i),  32'(readdatavalid0), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_valid_right", i), 32'(readdatavalid1), 32'(tbl[i].ev));
         if (tbl[i].ev || tbl[i].rs) begin
            chk($sformatf("vec%0d_data_left", i),  readdata0, tbl[i].d0);
            chk($sformatf("vec%0d_data_right", i), readdata1, tbl[i].d1);
         end
         chk($sformatf("vec%0d_ready", i), 32'(sample_ready0), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d_ovf", i),   32'(overflow0),     32'(tbl[i].ovf));
      end

      // Randomized traffic: an early fill-heavy phase, then a drain-heavy phase.
      for (int i = 0; i < 1500; i++) begin
         r64 = {$urandom(), $urandom()};
         st  = ($urandom_range(0, 9) < ((i < 600) ? 6 : 3));
         rd  = ($urandom_range(0, 1) == 1);
         r   = $urandom_range(0, 9);
         if (r < 4)      ad = 4'd1;
         else if (r < 7) ad = 4'd0;
         else if (r < 9) ad = 4'd2;
         else            ad = 4'($urandom_range(3, 15));
         rs  = ($urandom_range(0, 99) == 0);
         step(st, r64[47:0], rd, ad, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
